// File: rtl/fm_pkg.sv
// Shared FM-index definitions: step-engine state encoding, default alphabet size,
// and the Occ-row slicing helper shared with multi-lane engines.
package fm_pkg;

    localparam int unsigned SYM_W_DEF = 2;
    localparam int unsigned ALPHA     = 1 << SYM_W_DEF;
    localparam int unsigned ROW_MAX_W = 512;
    localparam int unsigned CNT_MAX_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CALC  = 3'd3,
        ST_DONE  = 3'd4
    } fm_state_e;

    // Extract the cnt_w-bit count of symbol sym from an Occ row (row zero-extended to ROW_MAX_W).
    function automatic logic [CNT_MAX_W-1:0] occ_slice(
        input logic [ROW_MAX_W-1:0] row,
        input int unsigned          sym,
        input int unsigned          cnt_w
    );
        logic [CNT_MAX_W-1:0] mask;
        mask = (cnt_w >= CNT_MAX_W) ? '1 : CNT_MAX_W'((64'd1 << cnt_w) - 64'd1);
        return CNT_MAX_W'(row >> (sym * cnt_w)) & mask;
    endfunction

endpackage

// File: rtl/fm_lat_counter.sv
// Saturating 3-bit down-counter that times the memory read latency of the step engine.
module fm_lat_counter
    import fm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    localparam int unsigned LAT_W = 3;

    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
        zero_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/fm_step_engine.sv
// One FM-index backward-search step: k' = C[a] + Occ(a,k-1) + 1, l' = C[a] + Occ(a,l),
// reading C/Occ memories of configurable latency behind a request/response handshake.
module fm_step_engine
    import fm_pkg::*;
#(
    parameter int unsigned SYM_W   = 2,
    parameter int unsigned IDX_W   = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MEM_LAT = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [IDX_W-1:0]                req_k,
    input  logic [IDX_W-1:0]                req_l,
    input  logic [SYM_W-1:0]                req_sym,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [IDX_W-1:0]                rsp_k,
    output logic [IDX_W-1:0]                rsp_l,
    output logic                            rsp_empty,
    output logic                            rsp_ovf,
    output logic                            ce_c_o,
    output logic [SYM_W-1:0]                addr_c_o,
    input  logic [CNT_W-1:0]                c_data_i,
    output logic                            ce_occ_o,
    output logic [IDX_W-1:0]                addr1_occ_o,
    output logic [IDX_W-1:0]                addr2_occ_o,
    input  logic [(2**SYM_W)*CNT_W-1:0]     occ1_i,
    input  logic [(2**SYM_W)*CNT_W-1:0]     occ2_i
);

    localparam int unsigned SUM_W = ((IDX_W > CNT_W) ? IDX_W : CNT_W) + 2;
    localparam int unsigned LAT_W = 3;

    fm_state_e        state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0] rsp_k_q, rsp_k_d;
    logic [IDX_W-1:0] rsp_l_q, rsp_l_d;
    logic             rsp_empty_q, rsp_empty_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             ce_q, ce_d;
    logic [SYM_W-1:0] addr_c_q, addr_c_d;
    logic [IDX_W-1:0] addr1_q, addr1_d;
    logic [IDX_W-1:0] addr2_q, addr2_d;
    logic             k_zero_q, k_zero_d;

    logic             cnt_load_c;
    logic             cnt_dec_c;
    logic             cnt_zero;

    logic [CNT_W-1:0] occ1_cnt_c;
    logic [CNT_W-1:0] occ2_cnt_c;
    logic [SUM_W-1:0] c_ext_c;
    logic [SUM_W-1:0] k_sum_c;
    logic [SUM_W-1:0] l_sum_c;
    logic             sum_ovf_c;

    fm_lat_counter u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load_c),
        .load_val_i (LAT_W'(MEM_LAT)),
        .dec_i      (cnt_dec_c),
        .zero_o     (cnt_zero)
    );

    // Full-width sums; Occ(a,-1) is forced to zero when k was zero.
    always_comb begin
        occ1_cnt_c = CNT_W'(occ_slice(ROW_MAX_W'(occ1_i), 32'(addr_c_q), CNT_W));
        occ2_cnt_c = CNT_W'(occ_slice(ROW_MAX_W'(occ2_i), 32'(addr_c_q), CNT_W));
        c_ext_c    = SUM_W'(c_data_i);
        k_sum_c    = c_ext_c + (k_zero_q ? '0 : SUM_W'(occ1_cnt_c)) + SUM_W'(1);
        l_sum_c    = c_ext_c + SUM_W'(occ2_cnt_c);
        sum_ovf_c  = (|k_sum_c[SUM_W-1:IDX_W]) | (|l_sum_c[SUM_W-1:IDX_W]);
    end

    always_comb begin
        state_d     = state_q;
        rsp_k_d     = rsp_k_q;
        rsp_l_d     = rsp_l_q;
        rsp_empty_d = rsp_empty_q;
        rsp_ovf_d   = rsp_ovf_q;
        addr_c_d    = addr_c_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        k_zero_d    = k_zero_q;
        cnt_load_c  = 1'b0;
        cnt_dec_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d    = ST_ISSUE;
                    addr_c_d   = req_sym;
                    addr1_d    = (req_k == '0) ? '0 : req_k - IDX_W'(1);
                    addr2_d    = req_l;
                    k_zero_d   = (req_k == '0);
                    cnt_load_c = 1'b1;
                end
            end
            ST_ISSUE: begin
                cnt_dec_c = 1'b1;
                state_d   = (MEM_LAT == 0) ? ST_CALC : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_dec_c = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                state_d     = ST_DONE;
                rsp_k_d     = IDX_W'(k_sum_c);
                rsp_l_d     = IDX_W'(l_sum_c);
                rsp_empty_d = (k_sum_c > l_sum_c);
                rsp_ovf_d   = sum_ovf_c;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake and enable outputs are decoded from the next state so they stay registered.
        ce_d        = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_CALC);
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_k_q     <= '0;
            rsp_l_q     <= '0;
            rsp_empty_q <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            ce_q        <= 1'b0;
            addr_c_q    <= '0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            k_zero_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_k_q     <= rsp_k_d;
            rsp_l_q     <= rsp_l_d;
            rsp_empty_q <= rsp_empty_d;
            rsp_ovf_q   <= rsp_ovf_d;
            ce_q        <= ce_d;
            addr_c_q    <= addr_c_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            k_zero_q    <= k_zero_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_k       = rsp_k_q;
    assign rsp_l       = rsp_l_q;
    assign rsp_empty   = rsp_empty_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign ce_c_o      = ce_q;
    assign ce_occ_o    = ce_q;
    assign addr_c_o    = addr_c_q;
    assign addr1_occ_o = addr1_q;
    assign addr2_occ_o = addr2_q;

endmodule

// File: tb/tb_fm_step_engine.sv
// Bench for fm_step_engine: lane 0 uses combinational memories, lane 1 two-cycle memories.
module tb_fm_step_engine;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic [7:0]  req_k     [2];
    logic [7:0]  req_l     [2];
    logic [1:0]  req_sym   [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [7:0]  rsp_k     [2];
    logic [7:0]  rsp_l     [2];
    logic        rsp_empty [2];
    logic        rsp_ovf   [2];
    logic        ce_c      [2];
    logic        ce_occ    [2];
    logic [1:0]  addr_c    [2];
    logic [7:0]  addr1     [2];
    logic [7:0]  addr2     [2];
    logic [7:0]  c_data    [2];
    logic [31:0] occ1      [2];
    logic [31:0] occ2      [2];

    int c_tab [4];
    bit ovr;
    int n_checks = 0;
    int n_errors = 0;

    fm_step_engine #(.SYM_W(2), .IDX_W(8), .CNT_W(8), .MEM_LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_k(req_k[0]), .req_l(req_l[0]), .req_sym(req_sym[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_k(rsp_k[0]), .rsp_l(rsp_l[0]), .rsp_empty(rsp_empty[0]), .rsp_ovf(rsp_ovf[0]),
        .ce_c_o(ce_c[0]), .addr_c_o(addr_c[0]), .c_data_i(c_data[0]),
        .ce_occ_o(ce_occ[0]), .addr1_occ_o(addr1[0]), .addr2_occ_o(addr2[0]),
        .occ1_i(occ1[0]), .occ2_i(occ2[0])
    );

    fm_step_engine #(.SYM_W(2), .IDX_W(8), .CNT_W(8), .MEM_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_k(req_k[1]), .req_l(req_l[1]), .req_sym(req_sym[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_k(rsp_k[1]), .rsp_l(rsp_l[1]), .rsp_empty(rsp_empty[1]), .rsp_ovf(rsp_ovf[1]),
        .ce_c_o(ce_c[1]), .addr_c_o(addr_c[1]), .c_data_i(c_data[1]),
        .ce_occ_o(ce_occ[1]), .addr1_occ_o(addr1[1]), .addr2_occ_o(addr2[1]),
        .occ1_i(occ1[1]), .occ2_i(occ2[1])
    );

    // Memory model: C from c_tab, Occ row r holds count(s) = r + s (sym 3 pinned to 5 when ovr).
    for (genvar g = 0; g < 2; g++) begin : g_rom
        logic [7:0]  c_now;
        logic [31:0] r1_now;
        logic [31:0] r2_now;

        always_comb begin
            c_now  = 8'(c_tab[addr_c[g]]);
            r1_now = '0;
            r2_now = '0;
            for (int s = 0; s < 4; s++) begin
                r1_now[s*8 +: 8] = (ovr && s == 3) ? 8'd5 : 8'(int'(addr1[g]) + s);
                r2_now[s*8 +: 8] = (ovr && s == 3) ? 8'd5 : 8'(int'(addr2[g]) + s);
            end
        end

        if (g == 0) begin : g_comb
            assign c_data[g] = c_now;
            assign occ1[g]   = r1_now;
            assign occ2[g]   = r2_now;
        end else begin : g_reg
            logic [7:0]  c_p  [2];
            logic [31:0] r1_p [2];
            logic [31:0] r2_p [2];
            always @(posedge clk) begin
                if (ce_c[g]) begin
                    c_p[0] <= c_now;
                    c_p[1] <= c_p[0];
                end
                if (ce_occ[g]) begin
                    r1_p[0] <= r1_now;
                    r1_p[1] <= r1_p[0];
                    r2_p[0] <= r2_now;
                    r2_p[1] <= r2_p[0];
                end
            end
            assign c_data[g] = c_p[1];
            assign occ1[g]   = r1_p[1];
            assign occ2[g]   = r2_p[1];
        end
    end

    function automatic int cnt_ref(input int r, input int s);
        if (ovr && s == 3) return 5;
        return (r + s) % 256;
    endfunction

    function automatic int ref_k(input int k, input int s);
        return c_tab[s] + ((k == 0) ? 0 : cnt_ref(k - 1, s)) + 1;
    endfunction

    function automatic int ref_l(input int l, input int s);
        return c_tab[s] + cnt_ref(l, s);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_req(input int ln, input int k, input int l, input int s);
        @(negedge clk);
        req_valid[ln] = 1'b1;
        req_k[ln]     = 8'(k);
        req_l[ln]     = 8'(l);
        req_sym[ln]   = 2'(s);
        chk("req_ready_idle", 64'(req_ready[ln]), 64'd1);
        @(negedge clk);
        req_valid[ln] = 1'b0;
    endtask

    // Entered one cycle after the accept edge (ISSUE); follows the request to DONE.
    task automatic wait_rsp(input int ln, input int k, input int l, input int s, input int lat);
        int cyc;
        int ks;
        int ls;
        ks = ref_k(k, s);
        ls = ref_l(l, s);
        chk("issue_ce_c", 64'(ce_c[ln]), 64'd1);
        chk("issue_ce_occ", 64'(ce_occ[ln]), 64'd1);
        chk("issue_addr_c", 64'(addr_c[ln]), 64'(s));
        chk("issue_addr1", 64'(addr1[ln]), 64'((k == 0) ? 0 : k - 1));
        chk("issue_addr2", 64'(addr2[ln]), 64'(l));
        chk("busy_req_ready", 64'(req_ready[ln]), 64'd0);
        cyc = 1;
        while (rsp_valid[ln] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2 + lat) begin
                chk("calc_ce_occ", 64'(ce_occ[ln]), 64'd1);
                chk("calc_addr1", 64'(addr1[ln]), 64'((k == 0) ? 0 : k - 1));
            end
        end
        chk("latency", 64'(cyc), 64'(3 + lat));
        chk("rsp_k", 64'(rsp_k[ln]), 64'(ks % 256));
        chk("rsp_l", 64'(rsp_l[ln]), 64'(ls % 256));
        chk("rsp_empty", 64'(rsp_empty[ln]), 64'(ks > ls));
        chk("rsp_ovf", 64'(rsp_ovf[ln]), 64'(ks >= 256 || ls >= 256));
        chk("done_ce", 64'(ce_occ[ln]), 64'd0);
    endtask

    task automatic finish_rsp(input int ln, input int delay);
        repeat (delay) @(negedge clk);
        rsp_ready[ln] = 1'b1;
        @(negedge clk);
        rsp_ready[ln] = 1'b0;
        chk("post_hs_rsp_valid", 64'(rsp_valid[ln]), 64'd0);
        chk("post_hs_req_ready", 64'(req_ready[ln]), 64'd1);
    endtask

    task automatic txn(input int ln, input int k, input int l, input int s, input int delay);
        send_req(ln, k, l, s);
        wait_rsp(ln, k, l, s, (ln == 0) ? 0 : 2);
        finish_rsp(ln, delay);
    endtask

    initial begin
        int lat;
        int hk;
        int hl;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_k[i]     = '0;
            req_l[i]     = '0;
            req_sym[i]   = '0;
            rsp_ready[i] = 1'b0;
        end
        c_tab = '{0, 10, 20, 30};
        ovr   = 1'b0;

        repeat (3) @(negedge clk);
        for (int ln = 0; ln < 2; ln++) begin
            chk("rst_req_ready", 64'(req_ready[ln]), 64'd1);
            chk("rst_rsp_valid", 64'(rsp_valid[ln]), 64'd0);
            chk("rst_rsp_k", 64'(rsp_k[ln]), 64'd0);
            chk("rst_rsp_flags", 64'({rsp_empty[ln], rsp_ovf[ln]}), 64'd0);
            chk("rst_ce", 64'({ce_c[ln], ce_occ[ln]}), 64'd0);
            chk("rst_addr", 64'({addr_c[ln], addr1[ln], addr2[ln]}), 64'd0);
        end
        rst_n = 1'b1;

        for (int ln = 0; ln < 2; ln++) begin
            txn(ln, 5, 9, 2, 0);
            txn(ln, 0, 3, 1, 0);
            ovr = 1'b1;
            txn(ln, 7, 7, 3, 1);
            ovr = 1'b0;
            c_tab[3] = 250;
            txn(ln, 200, 200, 3, 0);
            c_tab[3] = 30;
        end

        // Backpressure: response held while a second request waits.
        for (int ln = 0; ln < 2; ln++) begin
            lat = (ln == 0) ? 0 : 2;
            send_req(ln, 10, 20, 1);
            wait_rsp(ln, 10, 20, 1, lat);
            hk = ref_k(10, 1) % 256;
            hl = ref_l(20, 1) % 256;
            req_valid[ln] = 1'b1;
            req_k[ln]     = 8'd30;
            req_l[ln]     = 8'd60;
            req_sym[ln]   = 2'd0;
            repeat (10) begin
                @(negedge clk);
                chk("bp_rsp_valid", 64'(rsp_valid[ln]), 64'd1);
                chk("bp_rsp_k", 64'(rsp_k[ln]), 64'(hk));
                chk("bp_rsp_l", 64'(rsp_l[ln]), 64'(hl));
                chk("bp_req_ready", 64'(req_ready[ln]), 64'd0);
            end
            rsp_ready[ln] = 1'b1;
            @(negedge clk);
            rsp_ready[ln] = 1'b0;
            chk("bp_hs_rsp_valid", 64'(rsp_valid[ln]), 64'd0);
            chk("bp_hs_req_ready", 64'(req_ready[ln]), 64'd1);
            @(negedge clk);
            req_valid[ln] = 1'b0;
            wait_rsp(ln, 30, 60, 0, lat);
            finish_rsp(ln, 0);
        end

        // Reset while the two-cycle lane sits in WAIT.
        send_req(1, 5, 9, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready[1]), 64'd1);
        chk("mid_rst_rsp_valid", 64'(rsp_valid[1]), 64'd0);
        chk("mid_rst_ce", 64'({ce_c[1], ce_occ[1]}), 64'd0);
        chk("mid_rst_addr", 64'({addr_c[1], addr1[1], addr2[1]}), 64'd0);
        chk("mid_rst_rsp", 64'({rsp_k[1], rsp_l[1], rsp_empty[1], rsp_ovf[1]}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", 64'(rsp_valid[1]), 64'd0);
        end
        txn(1, 12, 40, 1, 0);

        // Random intervals, symbols and C contents on both lanes.
        repeat (24) begin
            int ln;
            int k;
            int l;
            int s;
            ln = int'($urandom_range(0, 1));
            k  = int'($urandom_range(0, 255));
            l  = int'($urandom_range(0, 255));
            s  = int'($urandom_range(0, 3));
            c_tab[s] = int'($urandom_range(0, 255));
            txn(ln, k, l, s, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
